// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_ptr.
// Returns the one-hot pick and its binary index.
module rr_priority_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      pick_idx
);

  int          cand;
  logic [IW-1:0] c;
  logic        found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    c        = '0;
    // Search starts one past the last owner and wraps modulo NUM_REQ
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      c = IW'(cand);
      if (!found && req[c]) begin
        found    = 1'b1;
        pick[c]  = 1'b1;
        pick_idx = c;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers, with bounded bursts and full/almostfull throttling.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_full,
  input  logic                          i_almostfull,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam int IW        = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);

  state_t               state_q, state_n;
  logic [NUM_REQ-1:0]   grant_q, grant_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic [IW-1:0]        last_q, last_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;

  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   ready;
  logic                 beat;
  logic                 gvalid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req      (i_req_valid),
    .last_ptr (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  assign ready  = (state_q == S_BURST && !i_full) ? grant_q : '0;
  assign beat   = |(ready & i_req_valid);
  assign gvalid = |(grant_q & i_req_valid);

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    idx_n   = idx_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|i_req_valid && !i_full) begin
          state_n = S_BURST;
          grant_n = pick;
          idx_n   = pick_idx;
          cnt_n   = '0;
        end
      end
      S_BURST: begin
        if (beat) cnt_n = cnt_q + CNT_WIDTH'(1);
        // Release on exhausted burst, FIFO pressure, or owner dropping valid
        if (!gvalid ||
            (beat && (cnt_q == LAST_BEAT || i_almostfull))) begin
          state_n = S_IDLE;
          grant_n = '0;
          last_n  = idx_q;
        end
      end
    endcase
  end

  always_comb begin
    o_wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) o_wr_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_req_ready = ready;
  assign o_wr_en     = beat;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q == S_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a
// queue-based behavioural model of the round-robin write arbiter.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ready;
  logic            full;
  logic            af;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [N-1:0]    grant;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (valid),
    .i_req_data   (data),
    .o_req_ready  (ready),
    .i_full       (full),
    .i_almostfull (af),
    .o_wr_en      (wr_en),
    .o_wr_data    (wr_data),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  logic [DW-1:0] q[N][$];
  logic [N-1:0]  drop;
  logic [DW-1:0] wlog[$];
  int            gtrace[$];
  int            etrace[$];
  int            errors = 0;
  int            checks = 0;

  // Model: owner index (-1 when idle), beats in current burst, last owner
  int m_owner;
  int m_cnt;
  int m_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) begin
      if (v[k]) r = (r == -1) ? k : 99;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = N - 1;
  endtask

  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      valid[k] = (q[k].size() > 0) && !drop[k];
      data[k*DW +: DW] = (q[k].size() > 0) ? q[k][0] : '0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ew;
    logic [DW-1:0] ed;
    if (rst) model_reset();
    eg = '0;
    er = '0;
    ew = 1'b0;
    ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!full) er[m_owner] = 1'b1;
      ew = !full && valid[m_owner];
      ed = data[m_owner*DW +: DW];
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("ready", 32'(ready), 32'(er));
    chk("wr_en", 32'(wr_en), 32'(ew));
    chk("wr_data", 32'(wr_data), 32'(ed));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    gtrace.push_back(onehot_idx(grant));
    etrace.push_back(int'(wr_en));
  endtask

  task automatic model_update();
    logic beat;
    int   c;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (|valid && !full) begin
        for (int off = 1; off <= N; off++) begin
          c = (m_last + off) % N;
          if (m_owner < 0 && valid[c]) m_owner = c;
        end
        m_cnt = 0;
      end
    end else begin
      beat = !full && valid[m_owner];
      if (beat) begin
        wlog.push_back(q[m_owner].pop_front());
        m_cnt++;
      end
      if (!valid[m_owner] || (beat && (m_cnt == MB || af))) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    drive_bus();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic restart();
    for (int k = 0; k < N; k++) q[k].delete();
    drop = '0;
    full = 1'b0;
    af   = 1'b0;
    rst  = 1'b1;
    cycle();
    rst  = 1'b0;
    gtrace.delete();
    etrace.delete();
    wlog.delete();
  endtask

  initial begin
    int exp_g;
    rst  = 1'b1;
    full = 1'b0;
    af   = 1'b0;
    drop = '0;
    valid = '0;
    data  = '0;
    model_reset();
    @(negedge clk);

    // Reset held with every requester valid
    for (int k = 0; k < N; k++) q[k].push_back(DW'(k + 1));
    repeat (3) cycle();
    chk("rst_grant", 32'(gtrace[2]), 32'(-1));
    chk("rst_wr_en", 32'(etrace[2]), 32'(0));

    // Single requester, six beats: burst of 4, one gap, then 2
    restart();
    for (int i = 0; i < 6; i++) q[0].push_back(DW'(8'hA0 + i));
    repeat (10) cycle();
    begin
      int pat[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
      for (int i = 0; i < 10; i++) chk("t2_wr_en", 32'(etrace[i]), 32'(pat[i]));
    end
    chk("t2_count", 32'(wlog.size()), 32'(6));
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("t2_order", 32'(wlog[i]), 32'(8'hA0 + i));

    // All requesters continuously valid: rotation 0,1,2,3,0
    restart();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 10; i++) q[k].push_back(DW'(16 * k + i));
    repeat (22) cycle();
    for (int i = 0; i < 22; i++) begin
      if (i == 0 || (i - 1) % 5 == 4) exp_g = -1;
      else exp_g = ((i - 1) / 5) % N;
      chk("t3_grant", 32'(gtrace[i]), 32'(exp_g));
    end

    // FIFO full for three cycles in the middle of req2's burst
    restart();
    for (int i = 0; i < 6; i++) q[2].push_back(DW'(8'h20 + i));
    repeat (3) cycle();
    full = 1'b1;
    repeat (3) cycle();
    full = 1'b0;
    repeat (3) cycle();
    for (int i = 3; i < 6; i++) begin
      chk("t4_hold", 32'(gtrace[i]), 32'(2));
      chk("t4_stall", 32'(etrace[i]), 32'(0));
    end
    chk("t4_resume", 32'(etrace[6] + etrace[7]), 32'(2));
    chk("t4_gap", 32'(gtrace[8]), 32'(-1));

    // Almostfull on req1's second beat ends the burst, req2 follows
    restart();
    for (int i = 0; i < 6; i++) q[1].push_back(DW'(8'h10 + i));
    for (int i = 0; i < 3; i++) q[2].push_back(DW'(8'h20 + i));
    repeat (2) cycle();
    af = 1'b1;
    cycle();
    af = 1'b0;
    repeat (3) cycle();
    chk("t5_beat2", 32'(etrace[2]), 32'(1));
    chk("t5_gap", 32'(gtrace[3]), 32'(-1));
    chk("t5_next", 32'(gtrace[4]), 32'(2));

    // Req3 releases after one beat; then reset mid-burst
    restart();
    for (int i = 0; i < 4; i++) q[3].push_back(DW'(8'h30 + i));
    repeat (2) cycle();
    drop[3] = 1'b1;
    cycle();
    drop[3] = 1'b0;
    repeat (3) cycle();
    chk("t6_drop_nowr", 32'(etrace[2]), 32'(0));
    chk("t6_release", 32'(gtrace[3]), 32'(-1));
    chk("t6_regrant", 32'(gtrace[4]), 32'(3));
    q[0].push_back(8'h01);
    q[0].push_back(8'h02);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    chk("t6_rst", 32'(gtrace[6]), 32'(-1));
    chk("t6_after_rst", 32'(gtrace[8]), 32'(0));

    // Randomised traffic, back-pressure, releases and resets
    restart();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if (q[k].size() == 0 && $urandom_range(0, 2) == 0)
          q[k].push_back(DW'($urandom_range(0, 255)));
        drop[k] = (q[k].size() > 0) && ($urandom_range(0, 19) == 0);
      end
      full = ($urandom_range(0, 5) == 0);
      af   = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
